// File: rtl/if_inst_queue.sv
// Dual-lane instruction queue at the IF-stage output.
// Buffers up to 2 fetched {pc,inst} entries per cycle and offers 2 in order to ID.
module if_inst_queue #(
  parameter  int DEPTH   = 8,
  parameter  int PC_W    = 32,
  parameter  int INST_W  = 32,
  localparam int ENTRY_W = PC_W + INST_W,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 branch_flush_i,
  input  logic                 excep_flush_i,
  input  logic                 fetch_valid1_i,
  input  logic                 fetch_valid2_i,
  input  logic [2*ENTRY_W-1:0] fetch_ibus,
  output logic                 fetch_allowin_o,
  input  logic                 now_allowin_i,
  output logic                 line1_pre_to_now_valid_o,
  output logic                 line2_pre_to_now_valid_o,
  output logic [2*ENTRY_W-1:0] to_if_id_obus,
  output logic [CW-1:0]        count_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               flush;
  logic               push_en;
  logic               wr1, wr2;
  logic [AW-1:0]      wr2_addr;
  logic [AW-1:0]      rd2_addr;
  logic               l1v, l2v;
  logic [CW-1:0]      npush, npop;

  // Push/pop accounting, offer generation and next-state pointers.
  always_comb begin
    flush    = branch_flush_i | excep_flush_i;
    fetch_allowin_o = (CW'(DEPTH) - count_q) >= CW'(2);
    push_en  = fetch_allowin_o & ~flush;
    wr1      = fetch_valid1_i & push_en;
    wr2      = fetch_valid2_i & push_en;
    wr2_addr = wr_ptr_q + AW'(wr1);
    rd2_addr = rd_ptr_q + AW'(1);
    npush    = CW'(wr1) + CW'(wr2);
    l1v      = (count_q != '0) & ~flush;
    l2v      = (count_q >= CW'(2)) & ~flush;
    npop     = '0;
    if (now_allowin_i) npop = CW'(l1v) + CW'(l2v);
    line1_pre_to_now_valid_o = l1v;
    line2_pre_to_now_valid_o = l2v;
    to_if_id_obus = '0;
    if (l1v) to_if_id_obus[ENTRY_W-1:0] = mem_q[rd_ptr_q];
    if (l2v) to_if_id_obus[2*ENTRY_W-1:ENTRY_W] = mem_q[rd2_addr];
    count_o  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + npop[AW-1:0];
      wr_ptr_d = wr_ptr_q + npush[AW-1:0];
      count_d  = count_q + npush - npop;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a lone lane2 entry lands at wr_ptr.
  always_ff @(posedge clk) begin
    if (wr1) mem_q[wr_ptr_q] <= fetch_ibus[ENTRY_W-1:0];
    if (wr2) mem_q[wr2_addr] <= fetch_ibus[2*ENTRY_W-1:ENTRY_W];
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) count_d <= CW'(DEPTH));

endmodule
